hdlc_rx_arbiter: RTL and testbench

HDLC_RX_ARBITER -- requirements
Module: hdlc_rx_arbiter

---
 rtl/hdlc_rx_arbiter_pkg.sv | 17 +
 rtl/hdlc_rx_arbiter_if.sv | 25 ++
 rtl/hdlc_rx_arbiter_rr_pick.sv | 31 +++
 rtl/hdlc_rx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_hdlc_rx_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/hdlc_rx_arbiter_pkg.sv
// rtl/hdlc_rx_arbiter_pkg.sv - shared state encodings and defaults for the HDLC receive arbiter
package hdlc_rx_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int CH_W            = 3;

    // Round-robin scan starts one past the last granted channel.
    function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] last, input int n);
        return (int'(last) == n - 1) ? '0 : last + 3'd1;
    endfunction

endpackage

// File: rtl/hdlc_rx_arbiter_if.sv
// rtl/hdlc_rx_arbiter_if.sv - channel FIFO heads and byte output bundle of the receive arbiter
interface hdlc_rx_arbiter_if #(
    parameter int N = 4
);
    logic [8*N-1:0] ch_data;
    logic [N-1:0]   ch_empty;
    logic [N-1:0]   ch_start;
    logic [N-1:0]   ch_get;
    logic [7:0]     out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_sof;
    logic [2:0]     out_ch;
    logic           out_abort;

    modport master (
        input  ch_data, ch_empty, ch_start, out_ready,
        output ch_get, out_data, out_valid, out_sof, out_ch, out_abort
    );

    modport slave (
        output ch_data, ch_empty, ch_start, out_ready,
        input  ch_get, out_data, out_valid, out_sof, out_ch, out_abort
    );
endinterface

// File: rtl/hdlc_rx_arbiter_rr_pick.sv
// rtl/hdlc_rx_arbiter_rr_pick.sv - round-robin pick of the first request at or after a pointer
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [2:0]   i_ptr,
    output logic         o_valid,
    output logic [2:0]   o_idx
);
    logic [3:0] w_dist;
    logic [3:0] w_best;

    // Winner is the requester with the smallest rotated distance from the pointer.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_best  = 4'hF;
        w_dist  = '0;
        for (int k = 0; k < N; k++) begin
            w_dist = 4'(k) + 4'(N) - {1'b0, i_ptr};
            if (w_dist >= 4'(N)) begin
                w_dist = w_dist - 4'(N);
            end
            if (i_req[k] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_valid = 1'b1;
                o_idx   = 3'(k);
            end
        end
    end
endmodule

// File: rtl/hdlc_rx_arbiter.sv
// rtl/hdlc_rx_arbiter.sv - frame-atomic round-robin merge of N HDLC receive FIFOs
// Optional empty-channel timeout enabled by HDLC_RX_ARBITER_TIMEOUT_EN.
module hdlc_rx_arbiter
    import hdlc_rx_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    hdlc_rx_arbiter_if.master bus
);
    state_t          r_state, w_next_state;
    logic [CH_W-1:0] r_lock, w_next_lock;
    logic [CH_W-1:0] r_last_grant, w_next_last;
    logic            r_first, w_next_first;
    logic [7:0]      r_out_data;
    logic            r_out_valid;
    logic            r_out_sof;
    logic [CH_W-1:0] r_out_ch;

    logic [N-1:0]    w_req;
    logic [CH_W-1:0] w_ptr;
    logic            w_pick_valid;
    logic [CH_W-1:0] w_pick_idx;
    logic            w_orph_valid;
    logic [CH_W-1:0] w_orph_idx;
    logic            w_lock_empty, w_lock_start;
    logic [7:0]      w_lock_data;
    logic            w_slot_free, w_pop, w_orph_pop;
    logic [N-1:0]    w_get;
`ifdef HDLC_RX_ARBITER_TIMEOUT_EN
    logic [7:0]      r_tmo;
    logic            r_out_abort;
    logic            w_abort;
`endif

    assign w_req       = bus.ch_start & ~bus.ch_empty;
    assign w_ptr       = rr_next(r_last_grant, N);
    assign w_slot_free = !r_out_valid || bus.out_ready;

    rr_pick #(.N(N)) u_rr_pick (
        .i_req   (w_req),
        .i_ptr   (w_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Locked-channel head and lowest orphan head (non-start byte with no frame around it).
    always_comb begin
        w_lock_empty = 1'b1;
        w_lock_start = 1'b0;
        w_lock_data  = '0;
        w_orph_valid = 1'b0;
        w_orph_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (r_lock == CH_W'(k)) begin
                w_lock_empty = bus.ch_empty[k];
                w_lock_start = bus.ch_start[k];
                w_lock_data  = bus.ch_data[8*k +: 8];
            end
            if (!bus.ch_empty[k] && !bus.ch_start[k]) begin
                w_orph_valid = 1'b1;
                w_orph_idx   = CH_W'(k);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_lock  = r_lock;
        w_next_last  = r_last_grant;
        w_next_first = r_first;
        w_pop        = 1'b0;
        w_orph_pop   = 1'b0;
`ifdef HDLC_RX_ARBITER_TIMEOUT_EN
        w_abort      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = GRANT;
                    w_next_lock  = w_pick_idx;
                    w_next_first = 1'b1;
                end else if (w_orph_valid) begin
                    w_orph_pop = 1'b1;
                end
            end
            GRANT: begin
                if (!w_lock_empty) begin
                    if (r_first || !w_lock_start) begin
                        if (w_slot_free) begin
                            w_pop        = 1'b1;
                            w_next_first = 1'b0;
                        end
                    end else begin
                        // Next frame's start byte stays in the FIFO for re-arbitration.
                        w_next_state = IDLE;
                        w_next_last  = r_lock;
                    end
                end
`ifdef HDLC_RX_ARBITER_TIMEOUT_EN
                else if (r_tmo == 8'(TIMEOUT - 1)) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                    w_next_last  = r_lock;
                end
`endif
            end
            default: w_next_state = IDLE;
        endcase
        for (int k = 0; k < N; k++) begin
            w_get[k] = (w_pop && (r_lock == CH_W'(k))) || (w_orph_pop && (w_orph_idx == CH_W'(k)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lock       <= '0;
            r_last_grant <= CH_W'(N - 1);
            r_first      <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_sof    <= 1'b0;
            r_out_ch     <= '0;
        end else begin
            r_state      <= w_next_state;
            r_lock       <= w_next_lock;
            r_last_grant <= w_next_last;
            r_first      <= w_next_first;
            if (w_pop) begin
                r_out_data  <= w_lock_data;
                r_out_valid <= 1'b1;
                r_out_sof   <= r_first;
                r_out_ch    <= r_lock;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
`ifdef HDLC_RX_ARBITER_TIMEOUT_EN
            if (w_abort) begin
                r_out_ch <= r_lock;
            end
`endif
        end
    end

`ifdef HDLC_RX_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo       <= '0;
            r_out_abort <= 1'b0;
        end else begin
            r_out_abort <= w_abort;
            if (r_state == GRANT && w_lock_empty && !w_abort) begin
                r_tmo <= r_tmo + 8'd1;
            end else begin
                r_tmo <= '0;
            end
        end
    end
    assign bus.out_abort = r_out_abort;
`else
    assign bus.out_abort = 1'b0;
`endif

    assign bus.ch_get    = reset ? '0 : w_get;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sof   = r_out_sof;
    assign bus.out_ch    = r_out_ch;
endmodule

// File: tb/tb_hdlc_rx_arbiter.sv
// tb/tb_hdlc_rx_arbiter.sv - directed self-checking bench for hdlc_rx_arbiter
module tb_hdlc_rx_arbiter;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hdlc_rx_arbiter_if #(.N(N)) bus ();

    hdlc_rx_arbiter #(.N(N), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [8:0]  ch_q [N][$];
    logic [11:0] out_q [$];
    int n_checks  = 0;
    int n_errs    = 0;
    int get3_cnt  = 0;
    int abort_cnt = 0;
    int valid_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            if (ch_q[k].size() > 0) begin
                bus.ch_empty[k]       = 1'b0;
                bus.ch_start[k]       = ch_q[k][0][8];
                bus.ch_data[8*k +: 8] = ch_q[k][0][7:0];
            end else begin
                bus.ch_empty[k]       = 1'b1;
                bus.ch_start[k]       = 1'b0;
                bus.ch_data[8*k +: 8] = 8'h00;
            end
        end
    endtask

    task automatic push(input int k, input logic s, input logic [7:0] d);
        ch_q[k].push_back({s, d});
        refresh();
    endtask

    // One clock: observe at the edge, pop the FIFOs the DUT asked for, settle at +2.
    task automatic tick();
        logic [N-1:0] g;
        @(posedge clk);
        g = bus.ch_get;
        if (bus.out_valid && bus.out_ready) out_q.push_back({bus.out_sof, bus.out_ch, bus.out_data});
        if (g[3]) get3_cnt++;
        if (bus.out_abort) abort_cnt++;
        if (bus.out_valid) valid_cnt++;
        #1;
        for (int k = 0; k < N; k++) begin
            if (g[k] && ch_q[k].size() > 0) void'(ch_q[k].pop_front());
        end
        refresh();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_reset();
        reset = 1'b1;
        for (int k = 0; k < N; k++) ch_q[k].delete();
        out_q.delete();
        bus.out_ready = 1'b1;
        refresh();
        tick();
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_out(input int n, input int budget);
        int b;
        b = budget;
        while (out_q.size() < n && b > 0) begin
            tick();
            b--;
        end
        check("out_count", 32'(out_q.size() >= n), 32'd1);
    endtask

    task automatic chk_out(input string tag, input int idx, input logic sof, input logic [2:0] ch,
                           input logic [7:0] d);
        logic [11:0] obs;
        obs = (idx < out_q.size()) ? out_q[idx] : 12'hxxx;
        check(tag, {20'd0, obs}, {20'd0, sof, ch, d});
    endtask

    initial begin
        int n;
        int base_get3, base_valid, base_abort;
        bus.out_ready = 1'b1;
        refresh();

        // Reset values and one frame followed by the next frame's start byte on ch0.
        start_reset();
        push(0, 1'b1, 8'hA1); push(0, 1'b0, 8'hA2); push(0, 1'b0, 8'hA3); push(0, 1'b1, 8'hB1);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sof",   32'(bus.out_sof),   32'd0);
        check("rst_data",  32'(bus.out_data),  32'd0);
        check("rst_ch",    32'(bus.out_ch),    32'd0);
        check("rst_abort", 32'(bus.out_abort), 32'd0);
        check("rst_get",   32'(bus.ch_get),    32'd0);
        release_reset();
        wait_out(4, 30);
        chk_out("t1_a1", 0, 1'b1, 3'd0, 8'hA1);
        chk_out("t1_a2", 1, 1'b0, 3'd0, 8'hA2);
        chk_out("t1_a3", 2, 1'b0, 3'd0, 8'hA3);
        chk_out("t1_b1", 3, 1'b1, 3'd0, 8'hB1);

        // Contested start on ch1 and ch2: frames must not interleave, then rotation favours ch2.
        start_reset();
        push(1, 1'b1, 8'hC1); push(1, 1'b0, 8'hC2); push(1, 1'b1, 8'hE1);
        push(2, 1'b1, 8'hD1); push(2, 1'b0, 8'hD2); push(2, 1'b1, 8'hF1);
        release_reset();
        wait_out(5, 40);
        chk_out("t2_c1", 0, 1'b1, 3'd1, 8'hC1);
        chk_out("t2_c2", 1, 1'b0, 3'd1, 8'hC2);
        chk_out("t2_d1", 2, 1'b1, 3'd2, 8'hD1);
        chk_out("t2_d2", 3, 1'b0, 3'd2, 8'hD2);
        chk_out("t2_e1", 4, 1'b1, 3'd1, 8'hE1);

        // Consumer stall mid-frame.
        start_reset();
        push(0, 1'b1, 8'h31); push(0, 1'b0, 8'h32); push(0, 1'b0, 8'h33); push(0, 1'b0, 8'h34);
        push(0, 1'b1, 8'h3F);
        release_reset();
        ticks(3);
        bus.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_data",  32'(bus.out_data),  32'h32);
            check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t3_hold_get",   32'(bus.ch_get),    32'd0);
        end
        bus.out_ready = 1'b1;
        wait_out(4, 20);
        chk_out("t3_g1", 0, 1'b1, 3'd0, 8'h31);
        chk_out("t3_g2", 1, 1'b0, 3'd0, 8'h32);
        chk_out("t3_g3", 2, 1'b0, 3'd0, 8'h33);
        chk_out("t3_g4", 3, 1'b0, 3'd0, 8'h34);

        // Orphan byte discarded while idle.
        start_reset();
        push(3, 1'b0, 8'h55);
        base_get3  = get3_cnt;
        base_valid = valid_cnt;
        release_reset();
        ticks(6);
        check("t4_get3_pulses", 32'(get3_cnt - base_get3),   32'd1);
        check("t4_no_valid",    32'(valid_cnt - base_valid), 32'd0);
        check("t4_ch3_empty",   32'(ch_q[3].size()),         32'd0);

        // Locked channel runs dry after its first byte.
        start_reset();
        push(0, 1'b1, 8'h11);
        base_abort = abort_cnt;
        release_reset();
        ticks(2);
        check("t5_first_data", 32'(bus.out_data), 32'h11);
`ifdef HDLC_RX_ARBITER_TIMEOUT_EN
        n = 0;
        while (!bus.out_abort && n < 20) begin
            tick();
            n++;
        end
        check("t5_abort_delay", 32'(n),           32'd4);
        check("t5_abort_ch",    32'(bus.out_ch),  32'd0);
        tick();
        check("t5_abort_pulse", 32'(bus.out_abort), 32'd0);
        push(1, 1'b1, 8'h22);
        wait_out(2, 10);
        chk_out("t5_regrant", 1, 1'b1, 3'd1, 8'h22);
`else
        n = 0;
        ticks(10);
        check("t5_no_abort", 32'(abort_cnt - base_abort), 32'd0);
        push(1, 1'b1, 8'h22);
        ticks(6);
        check("t5_still_locked", 32'(out_q.size()), 32'd1);
`endif

        // Reset mid-frame, then a fully contested restart.
        start_reset();
        push(0, 1'b1, 8'h41); push(0, 1'b0, 8'h42); push(0, 1'b0, 8'h43); push(0, 1'b0, 8'h44);
        release_reset();
        ticks(3);
        check("t6_pre_get", 32'(bus.ch_get), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(bus.out_valid),  32'd0);
        check("t6_rst_get",   32'(bus.ch_get),     32'd0);
        check("t6_fifo_kept", 32'(ch_q[0].size()), 32'd2);
        start_reset();
        for (int k = 0; k < N; k++) push(k, 1'b1, 8'(8'h80 + k));
        release_reset();
        wait_out(1, 10);
        chk_out("t6_first_grant", 0, 1'b1, 3'd0, 8'h80);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
